muldiv_seq: RTL and testbench

- Iterative RV32M multiply/divide sequencer placed beside the ALU in the Execute stage.
- Takes M-extension ops that the single-cycle ALU cannot do.
- Runs a 32-step shift-add multiply or a restoring divide, and holds the pipeline stall until the result is ready.
- The Execute-stage result mux selects result_o when result_valid_o is high.

---
 rtl/muldiv_pkg.sv | 63 ++++++
 rtl/muldiv_seq_if.sv | 25 ++
 rtl/muldiv_negate.sv | 13 +
 rtl/muldiv_seq.sv | 215 +++++++++++++++++++++
 tb/tb_muldiv_seq.sv | 378 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types, constants and helpers
// for the RV32M iterative multiply/divide sequencer.
package muldiv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] INT_MIN   = 32'h8000_0000;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } muldiv_state_e;

  function automatic logic op_is_div(
    input muldiv_op_e op
  );
    return op[2];
  endfunction

  function automatic logic op_is_rem(
    input muldiv_op_e op
  );
    return op[2] & op[1];
  endfunction

  function automatic logic op_sgn_a(
    input muldiv_op_e op
  );
    return op inside {OP_MULH, OP_MULHSU,
                      OP_DIV, OP_REM};
  endfunction

  function automatic logic op_sgn_b(
    input muldiv_op_e op
  );
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

  function automatic logic [XLEN-1:0] special_res(
    input muldiv_op_e      op,
    input logic [XLEN-1:0] a,
    input logic            div0
  );
    if (div0)
      return op_is_rem(op) ? a : DIV0_QUOT;
    return op_is_rem(op) ? '0 : INT_MIN;
  endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: Execute-stage request/result bundle
// between the pipeline (master) and the sequencer (slave).
interface muldiv_seq_if;
  import muldiv_pkg::*;

  logic            start_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] SrcAE;
  logic [XLEN-1:0] SrcBE;
  logic            flush_i;
  logic            stall_o;
  logic            result_valid_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output start_i, op_i, SrcAE, SrcBE, flush_i,
    input  stall_o, result_valid_o, result_o
  );

  modport slave (
    input  start_i, op_i, SrcAE, SrcBE, flush_i,
    output stall_o, result_valid_o, result_o
  );

endinterface

// File: rtl/muldiv_negate.sv
// muldiv_negate: conditional two's complement,
// used for operand magnitudes and result sign fix.
module muldiv_negate
  import muldiv_pkg::*;
(
  input  logic            neg_i,
  input  logic [XLEN-1:0] a_i,
  output logic [XLEN-1:0] y_o
);

  assign y_o = neg_i ? -a_i : a_i;

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M mul/div beside the EX ALU.
// Build option MULDIV_EARLY_OUT_EN: 2-cycle special/zero ops.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input logic         clk,
  input logic         rst_n,
  muldiv_seq_if.slave bus
);

  muldiv_state_e state_q, state_d;
  muldiv_op_e    op_in, op_q;

  logic [XLEN-1:0]   a_in, b_in;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic              sa, sb;
  logic              neg_in, div0_in, ovf_in;
  logic              accept, go_done;

  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   opb_q, orig_a_q, res_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              neg_q, div0_q, ovf_q;
  logic              last_step;

  logic [XLEN-1:0]   addend;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     rem_sh;
  logic [XLEN-1:0]   rem_sub;
  logic              rem_ge;
  logic [2*XLEN-1:0] div_next;

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   sel_word, sel_fix;
  logic [XLEN-1:0]   fix_res;

  logic              stall, valid;

  assign op_in = muldiv_op_e'(bus.op_i);
  assign a_in  = bus.SrcAE;
  assign b_in  = bus.SrcBE;

  assign sa = op_sgn_a(op_in) & a_in[XLEN-1];
  assign sb = op_sgn_b(op_in) & b_in[XLEN-1];

  assign neg_in  = op_is_rem(op_in) ? sa : sa ^ sb;
  assign div0_in = op_is_div(op_in)
                 & (b_in == '0);
  assign ovf_in  = op_is_div(op_in)
                 & op_sgn_a(op_in)
                 & (a_in == INT_MIN)
                 & (b_in == '1);

  assign accept = (state_q == S_IDLE)
                & bus.start_i
                & ~bus.flush_i;

  muldiv_negate u_abs_a (
    .neg_i (sa),
    .a_i   (a_in),
    .y_o   (abs_a)
  );

  muldiv_negate u_abs_b (
    .neg_i (sb),
    .a_i   (b_in),
    .y_o   (abs_b)
  );

`ifdef MULDIV_EARLY_OUT_EN
  logic            zero_mul;
  logic [XLEN-1:0] early_res;

  assign zero_mul = ~op_is_div(op_in)
                  & ((a_in == '0) | (b_in == '0));
  assign go_done  = zero_mul | div0_in | ovf_in;
  assign early_res = zero_mul ? '0
                   : special_res(op_in, a_in, div0_in);
`else
  assign go_done = 1'b0;
`endif

  assign last_step = (cnt_q == CNT_W'(XLEN-1));

  // Shift-add multiply: low half holds the multiplier.
  assign addend   = acc_q[0] ? opb_q : '0;
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]}
                  + {1'b0, addend};
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

  // Restoring divide: 33-bit shifted partial remainder.
  assign rem_sh   = acc_q[2*XLEN-1:XLEN-1];
  assign rem_ge   = rem_sh >= {1'b0, opb_q};
  assign rem_sub  = rem_sh[XLEN-1:0] - opb_q;
  assign div_next = rem_ge
    ? {rem_sub, acc_q[XLEN-2:0], 1'b1}
    : {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};

  assign prod     = neg_q ? -acc_q : acc_q;
  assign sel_word = op_is_rem(op_q)
                  ? acc_q[2*XLEN-1:XLEN]
                  : acc_q[XLEN-1:0];

  muldiv_negate u_fix (
    .neg_i (neg_q),
    .a_i   (sel_word),
    .y_o   (sel_fix)
  );

  // Final result select with divide special cases.
  always_comb begin
    fix_res = sel_fix;
    unique case (1'b1)
      div0_q | ovf_q:
        fix_res = special_res(op_q, orig_a_q, div0_q);
      op_q == OP_MUL:
        fix_res = prod[XLEN-1:0];
      ~op_is_div(op_q) & (op_q != OP_MUL):
        fix_res = prod[2*XLEN-1:XLEN];
      default:
        fix_res = sel_fix;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  // Next state; flush returns to IDLE from anywhere.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (accept)
          state_d = go_done ? S_DONE : S_CALC;
      S_CALC:
        if (last_step)
          state_d = S_FIX;
      S_FIX:
        state_d = S_DONE;
      S_DONE:
        state_d = S_IDLE;
    endcase
    if (bus.flush_i)
      state_d = S_IDLE;
  end

  // Stall and result-valid decode.
  always_comb begin
    stall = 1'b0;
    valid = 1'b0;
    unique case (state_q)
      S_IDLE: stall = bus.start_i & ~bus.flush_i;
      S_CALC: stall = 1'b1;
      S_FIX:  stall = 1'b1;
      S_DONE: valid = 1'b1;
    endcase
    if (!rst_n)
      stall = 1'b0;
  end

  // Operand latch, iteration datapath and result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= OP_MUL;
      acc_q    <= '0;
      opb_q    <= '0;
      orig_a_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      res_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q     <= op_in;
            acc_q    <= {{XLEN{1'b0}}, abs_a};
            opb_q    <= abs_b;
            orig_a_q <= a_in;
            cnt_q    <= '0;
            neg_q    <= neg_in;
            div0_q   <= div0_in;
            ovf_q    <= ovf_in;
`ifdef MULDIV_EARLY_OUT_EN
            if (go_done)
              res_q <= early_res;
`endif
          end
        end
        S_CALC: begin
          acc_q <= op_is_div(op_q) ? div_next
                                   : mul_next;
          cnt_q <= cnt_q + 1'b1;
        end
        S_FIX: res_q <= fix_res;
        default: ;
      endcase
    end
  end

  assign bus.stall_o        = stall;
  assign bus.result_valid_o = valid;
  assign bus.result_o       = res_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: scoreboard bench for muldiv_seq
// (reset, mul, div, specials, flush, async reset).
module tb_muldiv_seq;
  import muldiv_pkg::*;

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  muldiv_seq_if bus ();

  muldiv_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] ref_res(
    input logic [2:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [63:0] p;
    logic [63:0] ea, eb;
    ea = {{32{a[31]}}, a};
    eb = {{32{b[31]}}, b};
    p  = '0;
    case (op)
      3'd0: begin
        p = {32'b0, a} * {32'b0, b};
        return p[31:0];
      end
      3'd1: begin
        p = ea * eb;
        return p[63:32];
      end
      3'd2: begin
        p = ea * {32'b0, b};
        return p[63:32];
      end
      3'd3: begin
        p = {32'b0, a} * {32'b0, b};
        return p[63:32];
      end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          return 32'h8000_0000;
        return $signed(a) / $signed(b);
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          return 32'd0;
        return $signed(a) % $signed(b);
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic bit is_special(
    input logic [2:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    if (!op[2])
      return (a == 32'd0) || (b == 32'd0);
    if (b == 32'd0)
      return 1'b1;
    return !op[0] && a == 32'h8000_0000
        && b == 32'hFFFF_FFFF;
  endfunction

  function automatic int exp_lat(
    input logic [2:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    return (EARLY && is_special(op, a, b)) ? 1 : 34;
  endfunction

  function automatic int exp_stl(
    input logic [2:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    return (EARLY && is_special(op, a, b)) ? 0 : 33;
  endfunction

  // Issue one op, hold start while stalled, capture
  // result, edges to valid and stalled cycles after accept.
  task automatic do_op(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res,
    output int          lat,
    output int          stl,
    output logic        st0
  );
    res = 'x;
    lat = 0;
    stl = 0;
    @(negedge clk);
    bus.op_i    = op;
    bus.SrcAE   = a;
    bus.SrcBE   = b;
    bus.start_i = 1'b1;
    #1;
    st0 = bus.stall_o;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) begin
        bus.SrcAE = $urandom;
        bus.SrcBE = $urandom;
      end
      if (bus.result_valid_o) begin
        res = bus.result_o;
        lat = n;
        break;
      end
      if (bus.stall_o) stl++;
    end
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  task automatic test_reset();
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.op_i    = 3'd0;
    bus.SrcAE   = '0;
    bus.SrcBE   = '0;
    rst_n       = 1'b0;
    #3;
    total++;
    if (bus.stall_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_stall got=%b exp=0",
               bus.stall_o);
    end
    total++;
    if (bus.result_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_valid got=%b exp=0",
               bus.result_valid_o);
    end
    total++;
    if (bus.result_o !== 32'd0) begin
      bad++;
      $display("FAIL reset_result got=%h exp=0",
               bus.result_o);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mul();
    logic [31:0] r, e;
    int lat, stl;
    logic st0;
    exp_q.push_back(32'hFFFF_FFEB);
    do_op(3'd0, 32'd7, 32'hFFFF_FFFD,
          r, lat, stl, st0);
    e = exp_q.pop_front();
    total++;
    if (r !== e) begin
      bad++;
      $display("FAIL mul_7x-3 got=%h exp=%h", r, e);
    end
    total++;
    if (st0 !== 1'b1) begin
      bad++;
      $display("FAIL mul_accept_stall got=%b exp=1",
               st0);
    end
    total++;
    if (stl != 33) begin
      bad++;
      $display("FAIL mul_stall_cycles got=%0d exp=33",
               stl);
    end
    total++;
    if (lat != 34) begin
      bad++;
      $display("FAIL mul_latency got=%0d exp=34", lat);
    end
    @(posedge clk);
    #1;
    total++;
    if (bus.result_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL mul_valid_pulse got=%b exp=0",
               bus.result_valid_o);
    end
  endtask

  // Table-driven ops with scoreboard result/latency checks.
  task automatic run_table(
    input string       tag,
    input logic [2:0]  ops[],
    input logic [31:0] as[],
    input logic [31:0] bs[]
  );
    logic [31:0] r, e;
    int lat, stl;
    logic st0;
    for (int i = 0; i < ops.size(); i++) begin
      exp_q.push_back(ref_res(ops[i], as[i], bs[i]));
      do_op(ops[i], as[i], bs[i], r, lat, stl, st0);
      e = exp_q.pop_front();
      total++;
      if (r !== e) begin
        bad++;
        $display("FAIL %s[%0d] op=%0d got=%h exp=%h",
                 tag, i, ops[i], r, e);
      end
      total++;
      if (lat != exp_lat(ops[i], as[i], bs[i])) begin
        bad++;
        $display("FAIL %s_lat[%0d] got=%0d exp=%0d",
                 tag, i, lat,
                 exp_lat(ops[i], as[i], bs[i]));
      end
      total++;
      if (stl != exp_stl(ops[i], as[i], bs[i])) begin
        bad++;
        $display("FAIL %s_stl[%0d] got=%0d exp=%0d",
                 tag, i, stl,
                 exp_stl(ops[i], as[i], bs[i]));
      end
    end
  endtask

  task automatic test_mulh();
    run_table("mulh",
      '{3'd3, 3'd1, 3'd2},
      '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
      '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2});
  endtask

  task automatic test_div();
    run_table("div",
      '{3'd4, 3'd6, 3'd5, 3'd7},
      '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100},
      '{32'd2, 32'd2, 32'd7, 32'd7});
  endtask

  task automatic test_special();
    run_table("spec",
      '{3'd4, 3'd6, 3'd4, 3'd6, 3'd0},
      '{32'd5, 32'd5, 32'h8000_0000,
        32'h8000_0000, 32'd0},
      '{32'd0, 32'd0, 32'hFFFF_FFFF,
        32'hFFFF_FFFF, 32'd1234});
  endtask

  task automatic test_flush();
    @(negedge clk);
    bus.op_i    = 3'd0;
    bus.SrcAE   = 32'd3;
    bus.SrcBE   = 32'd5;
    bus.start_i = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    bus.flush_i = 1'b1;
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (bus.stall_o !== 1'b0) begin
      bad++;
      $display("FAIL flush_stall got=%b exp=0",
               bus.stall_o);
    end
    total++;
    if (bus.result_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL flush_valid got=%b exp=0",
               bus.result_valid_o);
    end
    @(negedge clk);
    bus.flush_i = 1'b0;
    run_table("postflush",
      '{3'd5}, '{32'd100}, '{32'd7});
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus.op_i    = 3'd3;
    bus.SrcAE   = 32'hFFFF_FFFF;
    bus.SrcBE   = 32'hFFFF_FFFF;
    bus.start_i = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.stall_o !== 1'b0) begin
      bad++;
      $display("FAIL arst_stall got=%b exp=0",
               bus.stall_o);
    end
    total++;
    if (bus.result_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL arst_valid got=%b exp=0",
               bus.result_valid_o);
    end
    total++;
    if (bus.result_o !== 32'd0) begin
      bad++;
      $display("FAIL arst_result got=%h exp=0",
               bus.result_o);
    end
    @(negedge clk);
    bus.start_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_table("postrst",
      '{3'd7}, '{32'd9}, '{32'd4});
  endtask

  task automatic test_back_to_back();
    logic [2:0]  ops[];
    logic [31:0] as[];
    logic [31:0] bs[];
    logic [31:0] pool[8];
    pool = '{32'd0, 32'd1, 32'hFFFF_FFFF,
             32'h8000_0000, 32'h7FFF_FFFF,
             32'd13, 32'hDEAD_BEEF, 32'hFFFF_FFF3};
    ops = new[12];
    as  = new[12];
    bs  = new[12];
    for (int i = 0; i < 12; i++) begin
      ops[i] = 3'($urandom_range(7));
      as[i]  = (i % 3 == 0) ? $urandom
             : pool[$urandom_range(7)];
      bs[i]  = (i % 4 == 1) ? $urandom
             : pool[$urandom_range(7)];
    end
    run_table("b2b", ops, as, bs);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
